mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the RISC core's single-port unified memory (4096 x 32). It shares the memory between the instruction-fetch port and the load/store data port. It applies round-robin priority on contention, turns each granted request into one memory access, and returns read data with a fixed latency. It sits between the core's fetch/execute control and the memory array.

---
 rtl/risc_mem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_mem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package risc_mem_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int ADDRSIZE_DEF = 12;
  localparam int MEMSIZE_DEF  = 1 << ADDRSIZE_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the requester not granted last time wins.
module rr_arb2
  import risc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,     // bit 0 = fetch, bit 1 = data
  input  logic       i_update,
  output owner_t     o_winner
);

  owner_t r_last;

  always_comb begin
    o_winner = OWN_IF;
    if (i_req == 2'b11) o_winner = (r_last == OWN_IF) ? OWN_D : OWN_IF;
    else if (i_req[1])  o_winner = OWN_D;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last <= OWN_IF;
    else if (i_update) r_last <= o_winner;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory and
// sequences each grant into one access with fixed-latency read return.
module mem_port_arbiter
  import risc_mem_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDRSIZE-1:0] if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [WIDTH-1:0]    if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDRSIZE-1:0] d_addr,
  input  logic [WIDTH-1:0]    d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WIDTH-1:0]    d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                busy
);

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t              r_state;
  owner_t              r_owner;
  logic                r_we;
  logic [ADDRSIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_wdata;
  logic [2:0]          r_cnt;
  logic [WIDTH-1:0]    r_if_rdata, r_d_rdata;
  logic                r_if_gnt, r_d_gnt, r_mem_en, r_mem_we;
  logic                r_if_rvalid, r_d_rvalid, r_busy;

  logic   w_grant;
  owner_t w_winner;

  assign w_grant = (r_state == IDLE) && (if_req || d_req);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({d_req, if_req}),
    .i_update (w_grant),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them for one cycle.
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      unique case (r_state)
        IDLE: if (w_grant) begin
          r_owner  <= w_winner;
          r_we     <= (w_winner == OWN_D) && d_we;
          r_addr   <= (w_winner == OWN_D) ? d_addr : if_addr;
          r_wdata  <= (w_winner == OWN_D) ? d_wdata : '0;
          r_mem_en <= 1'b1;
          r_mem_we <= (w_winner == OWN_D) && d_we;
          r_if_gnt <= (w_winner == OWN_IF);
          r_d_gnt  <= (w_winner == OWN_D);
          r_busy   <= 1'b1;
          r_state  <= ACCESS;
        end
        ACCESS: if (r_we) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_cnt   <= CNT_INIT;
          r_state <= WAIT;
        end
        WAIT: if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end else begin
          if (r_owner == OWN_D) r_d_rdata  <= mem_rdata;
          else                  r_if_rdata <= mem_rdata;
          r_if_rvalid <= (r_owner == OWN_IF);
          r_d_rvalid  <= (r_owner == OWN_D);
          r_state     <= RESP;
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter lanes (MEM_LAT 1 and 4), each with a behavioural memory and a
// transaction-timing model compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        if_req[2], d_req[2], d_we[2];
  logic [11:0] if_addr[2], d_addr[2], mem_addr[2];
  logic [31:0] d_wdata[2], if_rdata[2], d_rdata[2], mem_wdata[2], mem_rdata[2];
  logic        if_gnt[2], if_rvalid[2], d_gnt[2], d_rvalid[2];
  logic        mem_en[2], mem_we[2], busy[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    logic [11:0] a;
    a = i[11:0];
    return (i == 5) ? 32'h2000_0007 : {20'hA5A5A, a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 1 : 4;

    logic [31:0] mem [4096];
    logic [31:0] pipe [8];
    logic [31:0] ref_mem [4096];

    mem_port_arbiter #(.WIDTH(32), .ADDRSIZE(12), .MEM_LAT(L)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
      .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    initial for (int i = 0; i < 4096; i++) mem[i] = init_val(i);

    // Memory: read data appears L cycles after the enable cycle, poison otherwise.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hBAD0_0000;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
    end
    assign mem_rdata[g] = pipe[L-1];

    // Transaction model: a grant at edge e0 gives ACCESS after e0, RESP after
    // e0+L+1; the arbiter samples again at e0+2 (store) or e0+L+3 (read).
    int          e, e0, free_at, dlt;
    bit          act, own_d, we, last_d, acc, rsp, bz;
    logic [11:0] addr;
    logic [31:0] wdata, rd_val, exp_if_rd, exp_d_rd;

    task automatic mreset();
      act = 1'b0; free_at = 0; last_d = 1'b0;
      exp_if_rd = '0; exp_d_rd = '0;
    endtask

    initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
      e = 0; e0 = 0; mreset();
      forever begin
        @(posedge clk);
        e++;
        if (reset) mreset();
        else begin
          if (act && !we && e == e0 + L + 1) begin
            if (own_d) exp_d_rd = rd_val;
            else       exp_if_rd = rd_val;
          end
          if (e >= free_at && (if_req[g] || d_req[g])) begin
            own_d  = (if_req[g] && d_req[g]) ? !last_d : d_req[g];
            last_d = own_d;
            we     = own_d && d_we[g];
            addr   = own_d ? d_addr[g] : if_addr[g];
            wdata  = d_wdata[g];
            act    = 1'b1;
            e0     = e;
            if (we) begin
              ref_mem[addr] = wdata;
              free_at = e + 2;
            end else begin
              rd_val  = ref_mem[addr];
              free_at = e + L + 3;
            end
          end
        end
        @(negedge clk);
        if (reset) begin
          mreset();
          check($sformatf("lane%0d rst if_gnt", g), 32'(if_gnt[g]), 0);
          check($sformatf("lane%0d rst d_gnt", g), 32'(d_gnt[g]), 0);
          check($sformatf("lane%0d rst mem_en", g), 32'(mem_en[g]), 0);
          check($sformatf("lane%0d rst mem_we", g), 32'(mem_we[g]), 0);
          check($sformatf("lane%0d rst busy", g), 32'(busy[g]), 0);
          check($sformatf("lane%0d rst rvalid", g), 32'({if_rvalid[g], d_rvalid[g]}), 0);
          check($sformatf("lane%0d rst mem_addr", g), 32'(mem_addr[g]), 0);
          check($sformatf("lane%0d rst mem_wdata", g), mem_wdata[g], 0);
          check($sformatf("lane%0d rst if_rdata", g), if_rdata[g], 0);
          check($sformatf("lane%0d rst d_rdata", g), d_rdata[g], 0);
        end else begin
          dlt = e - e0;
          acc = act && dlt == 0;
          rsp = act && !we && dlt == L + 1;
          bz  = act && (we ? dlt == 0 : dlt <= L + 1);
          check($sformatf("lane%0d if_gnt", g), 32'(if_gnt[g]), 32'(acc && !own_d));
          check($sformatf("lane%0d d_gnt", g), 32'(d_gnt[g]), 32'(acc && own_d));
          check($sformatf("lane%0d mem_en", g), 32'(mem_en[g]), 32'(acc));
          check($sformatf("lane%0d mem_we", g), 32'(mem_we[g]), 32'(acc && we));
          check($sformatf("lane%0d busy", g), 32'(busy[g]), 32'(bz));
          check($sformatf("lane%0d if_rvalid", g), 32'(if_rvalid[g]), 32'(rsp && !own_d));
          check($sformatf("lane%0d d_rvalid", g), 32'(d_rvalid[g]), 32'(rsp && own_d));
          check($sformatf("lane%0d if_rdata", g), if_rdata[g], exp_if_rd);
          check($sformatf("lane%0d d_rdata", g), d_rdata[g], exp_d_rd);
          if (acc) check($sformatf("lane%0d mem_addr", g), 32'(mem_addr[g]), 32'(addr));
          if (acc && we) check($sformatf("lane%0d mem_wdata", g), mem_wdata[g], wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, gnt_at, rv_at, ifg_at, ifrv_at, bcnt;
  logic [31:0] rd, ifrd;

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      if_req[g] = 0; if_addr[g] = '0; d_req[g] = 0; d_we[g] = 0;
      d_addr[g] = '0; d_wdata[g] = '0;
    end
    tick();
    check("reset busy", 32'(busy[0]), 0);
    check("reset if_rdata", if_rdata[0], 0);
    tick(); tick();
    reset = 1'b0;

    // Lone fetch of address 5 on the MEM_LAT=1 lane.
    tick();
    if_req[0] = 1; if_addr[0] = 12'h005;
    tick();
    check("t1 if_gnt", 32'(if_gnt[0]), 1);
    check("t1 d_gnt", 32'(d_gnt[0]), 0);
    check("t1 mem_addr", 32'(mem_addr[0]), 32'h005);
    if_req[0] = 0;
    tick();
    check("t1 early rvalid", 32'(if_rvalid[0]), 0);
    tick();
    check("t1 if_rvalid", 32'(if_rvalid[0]), 1);
    check("t1 if_rdata", if_rdata[0], 32'h2000_0007);
    check("t1 d_rvalid", 32'(d_rvalid[0]), 0);
    tick();

    // Tie after reset: data first; tie again while fetch waits: fetch first.
    if_req[0] = 1; if_addr[0] = 12'h001;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 12'h100;
    tick();
    check("t2 d_gnt first", 32'(d_gnt[0]), 1);
    check("t2 if_gnt not first", 32'(if_gnt[0]), 0);
    d_req[0] = 0;
    tick();
    d_req[0] = 1; d_addr[0] = 12'h101;
    tick();
    check("t2 d_rdata", d_rdata[0], 32'hA5A5_A100);
    tick(); tick();
    check("t2 if_gnt second tie", 32'(if_gnt[0]), 1);
    check("t2 d_gnt second tie", 32'(d_gnt[0]), 0);
    if_req[0] = 0;
    tick(); tick();
    check("t2 if_rdata", if_rdata[0], 32'hA5A5_A001);
    tick(); tick();
    check("t2 d_gnt after fetch", 32'(d_gnt[0]), 1);
    d_req[0] = 0;
    tick(); tick();
    check("t2 d_rdata 101", d_rdata[0], 32'hA5A5_A101);
    tick();

    // Store then load back the same word.
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 12'h0FF; d_wdata[0] = 32'hDEAD_BEEF;
    tick();
    check("t3 store gnt", 32'(d_gnt[0]), 1);
    check("t3 store mem_we", 32'(mem_we[0]), 1);
    check("t3 store mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    d_req[0] = 0; d_we[0] = 0;
    tick();
    check("t3 store no rvalid", 32'(d_rvalid[0]), 0);
    check("t3 store idle", 32'(busy[0]), 0);
    d_req[0] = 1;
    tick();
    check("t3 load gnt", 32'(d_gnt[0]), 1);
    d_req[0] = 0;
    tick(); tick();
    check("t3 load rvalid", 32'(d_rvalid[0]), 1);
    check("t3 load data", d_rdata[0], 32'hDEAD_BEEF);
    tick();

    // Store request held two cycles past its grant issues a second store.
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 12'h010; d_wdata[0] = 32'h1234_5678;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (d_gnt[0]) n++;
      if (i == 4) begin d_req[0] = 0; d_we[0] = 0; end
    end
    check("t4 held req grants", n, 2);

    // MEM_LAT=4 load with a fetch raised mid-transaction.
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 12'h020;
    gnt_at = 0; rv_at = 0; ifg_at = 0; ifrv_at = 0; bcnt = 0; rd = '0; ifrd = '0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (d_gnt[1] && gnt_at == 0) begin gnt_at = i; d_req[1] = 0; end
      if (d_rvalid[1]) begin rv_at = i; rd = d_rdata[1]; end
      if (busy[1] && i <= 7) bcnt++;
      if (if_gnt[1]) begin ifg_at = i; if_req[1] = 0; end
      if (if_rvalid[1]) begin ifrv_at = i; ifrd = if_rdata[1]; end
      if (i == 3) begin if_req[1] = 1; if_addr[1] = 12'h003; end
    end
    check("t5 d_gnt cycle", gnt_at, 1);
    check("t5 d_rvalid cycle", rv_at, 6);
    check("t5 d_rdata", rd, 32'hA5A5_A020);
    check("t5 busy cycles", bcnt, 6);
    check("t5 if_gnt after resp", ifg_at, 8);
    check("t5 if_rvalid cycle", ifrv_at, 13);
    check("t5 if_rdata", ifrd, 32'hA5A5_A003);

    // Reset during WAIT drops the read; a new fetch is then served normally.
    if_req[1] = 1; if_addr[1] = 12'h004;
    tick();
    check("t6 gnt before reset", 32'(if_gnt[1]), 1);
    if_req[1] = 0;
    tick();
    reset = 1'b1;
    #1;
    check("t6 async busy", 32'(busy[1]), 0);
    check("t6 async if_rdata", if_rdata[1], 0);
    check("t6 async d_rdata", d_rdata[1], 0);
    tick(); tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if_rvalid[1]) n++;
    end
    check("t6 no rvalid after reset", n, 0);
    if_req[1] = 1; if_addr[1] = 12'h005;
    gnt_at = 0; rv_at = 0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (if_gnt[1] && gnt_at == 0) begin gnt_at = i; if_req[1] = 0; end
      if (if_rvalid[1]) begin rv_at = i; rd = if_rdata[1]; end
    end
    check("t6 post-reset gnt", gnt_at, 1);
    check("t6 post-reset rvalid", rv_at, 6);
    check("t6 post-reset data", rd, 32'h2000_0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
